// File: rtl/pipe_scheduler.sv
// Pipe obstacle scheduler: scrolls a pool of pipe slots, spawns/retires pipes and keeps score.
// Optional feature macro: PIPE_SPEEDUP_EN (scroll speed grows with score, capped at 4 px/frame).
module pipe_scheduler #(
    parameter int NUM_PIPES    = 3,
    parameter int SPEED        = 1,
    parameter int SPAWN_X      = 550,
    parameter int SPAWN_FRAMES = 120,
    parameter int GAP_MIN      = 80,
    parameter int BIRD_X       = 200
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   FrameTick,
    input  logic                   Start,
    input  logic                   Collide,
    input  logic                   Restart,
    output logic [10*NUM_PIPES-1:0] PipeX,
    output logic [10*NUM_PIPES-1:0] PipeY,
    output logic [NUM_PIPES-1:0]   PipeValid,
    output logic                   Running,
    output logic [7:0]             Score,
    output logic                   ScorePulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam logic [9:0] SPAWN_X_C  = 10'(SPAWN_X);
    localparam logic [9:0] GAP_MIN_C  = 10'(GAP_MIN);
    localparam logic [9:0] BIRD_X_C   = 10'(BIRD_X);
    localparam logic [9:0] SPEED_C    = 10'(SPEED);
    localparam logic [7:0] CNT_LAST_C = 8'(SPAWN_FRAMES - 1);

    function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
        return {cur[8:0], cur[9] ^ cur[6]};
    endfunction

    state_e                        state_q, state_d;
    logic [NUM_PIPES-1:0][9:0]     x_q, x_d;
    logic [NUM_PIPES-1:0][9:0]     y_q, y_d;
    logic [NUM_PIPES-1:0]          v_q, v_d;
    logic [7:0]                    score_q, score_d;
    logic                          pulse_q, pulse_d;
    logic                          running_q, running_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [9:0]                    lfsr_q;
    logic [9:0]                    speed_cur_s;
    logic [9:0]                    new_x_s;
    logic [2:0]                    events_s;
    logic [8:0]                    score_sum_s;
    logic                          taken_s;

`ifdef PIPE_SPEEDUP_EN
    logic [9:0] speed_sum_s;
    assign speed_sum_s = SPEED_C + {5'd0, score_q[7:3]};
    assign speed_cur_s = (speed_sum_s > 10'd4) ? 10'd4 : speed_sum_s;
`else
    assign speed_cur_s = SPEED_C;
`endif

    // Next-state logic for the game FSM, pipe slots, score and spawn counter.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        v_d         = v_q;
        score_d     = score_q;
        pulse_d     = 1'b0;
        cnt_d       = cnt_q;
        new_x_s     = 10'd0;
        events_s    = 3'd0;
        score_sum_s = 9'd0;
        taken_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                x_d     = '0;
                y_d     = '0;
                v_d     = '0;
                score_d = 8'd0;
                if (Start) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_LAST_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Collide) begin
                    state_d = ST_DEAD;
                end else if (FrameTick) begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (v_q[i]) begin
                            if (x_q[i] <= speed_cur_s) begin
                                v_d[i] = 1'b0;
                            end else begin
                                new_x_s = x_q[i] - speed_cur_s;
                                x_d[i]  = new_x_s;
                                if ((x_q[i] >= BIRD_X_C) && (new_x_s < BIRD_X_C)) begin
                                    events_s = events_s + 3'd1;
                                end else begin
                                    events_s = events_s;
                                end
                            end
                        end else begin
                            v_d[i] = 1'b0;
                        end
                    end
                    // Spawn only into a slot that was already free before this tick.
                    if (cnt_q == CNT_LAST_C) begin
                        cnt_d = 8'd0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            if (!v_q[i] && !taken_s) begin
                                taken_s = 1'b1;
                                x_d[i]  = SPAWN_X_C;
                                y_d[i]  = GAP_MIN_C + {3'b000, lfsr_q[6:0]};
                                v_d[i]  = 1'b1;
                            end else begin
                                taken_s = taken_s;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    score_sum_s = {1'b0, score_q} + {6'd0, events_s};
                    if (score_sum_s > 9'd255) begin
                        score_d = 8'd255;
                    end else begin
                        score_d = score_sum_s[7:0];
                    end
                    pulse_d = (events_s != 3'd0);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (Restart) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    v_d     = '0;
                    score_d = 8'd0;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
                v_d     = '0;
                score_d = 8'd0;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    // State and output registers; the LFSR free-runs in every state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            v_q       <= '0;
            score_q   <= 8'd0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= 8'd0;
            lfsr_q    <= 10'h001;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            v_q       <= v_d;
            score_q   <= score_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_next(lfsr_q);
        end
    end

    assign PipeX      = x_q;
    assign PipeY      = y_q;
    assign PipeValid  = v_q;
    assign Running    = running_q;
    assign Score      = score_q;
    assign ScorePulse = pulse_q;

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequences the pipe obstacles for the Flappy Bird datapath. Holds a small pool of pipe slots and scrolls every live pipe left once per video frame. Spawns new pipes at a fixed interval with a pseudo-random gap height, retires pipes at the left edge, and counts score as pipes pass the bird. Sits between the frame-timing logic and the per-pipe color-mapping logic, which consume its PipeX/PipeY/PipeValid outputs unchanged.

## Interface
- NUM_PIPES, 3: number of pipe slots (1..4)
- SPEED, 1: pixels moved per frame (1..4)
- SPAWN_X, 550: X assigned to a newly spawned pipe
- SPAWN_FRAMES, 120: frames between spawns (2..255)
- GAP_MIN, 80: minimum PipeY of a spawned pipe
- BIRD_X, 200: bird column used for scoring
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- FrameTick  in  1  one-Clk strobe per frame, synchronous to Clk
- Start  in  1  level; begins play from IDLE
- Collide  in  1  level; bird hit something
- Restart  in  1  level; return from DEAD to IDLE
- PipeX  out  10*NUM_PIPES  slot i at [10i+9:10i], left edge of pipe
- PipeY  out  10*NUM_PIPES  slot i gap-top Y
- PipeValid  out  NUM_PIPES  slot i live
- Running  out  1  state == RUN
- Score  out  8  pipes passed, saturates at 255
- ScorePulse  out  1  one-Clk pulse per increment

## Operation
- States: IDLE, RUN, DEAD. Reset -> IDLE.
- IDLE: all slots cleared. Start=1 -> RUN, spawn counter preloaded to SPAWN_FRAMES-1.
- RUN, FrameTick=1, Collide=0:
  - Each valid slot: if PipeX <= SPEED_cur, clear PipeValid (retire) and leave X unchanged. Otherwise PipeX -= SPEED_cur.
  - Score event: a slot with old X >= BIRD_X and new X < BIRD_X. Each event increments Score by 1, saturating at 255. ScorePulse is asserted if any event occurred. Multiple events in one tick add their count.
  - Spawn counter: if it equals SPAWN_FRAMES-1, wrap to 0 and spawn; else increment.
  - Spawn takes the lowest-index slot invalid before this tick. A slot retiring this tick is not eligible. The slot gets PipeX=SPAWN_X, PipeY=GAP_MIN+{3'b0,lfsr[6:0]}, PipeValid=1. No free slot -> spawn dropped; counter still wraps.
- RUN, Collide=1 -> DEAD. Collide wins over a same-cycle FrameTick: no move, spawn or score.
- DEAD: all outputs frozen. Restart=1 -> IDLE: clear slots, Score=0.
- Start in RUN/DEAD, and Restart in IDLE/RUN, are ignored.
- LFSR: 10-bit Fibonacci, taps 10,7. Free-running every Clk in every state. Reset seed 10'h001; never reaches zero.
- All arithmetic 10-bit unsigned. PipeY maximum is GAP_MIN+127; the integrator guarantees this stays on screen.

## Timing
- All outputs are registered.
- Reset values: PipeX=0, PipeY=0, PipeValid=0, Running=0, Score=0, ScorePulse=0, spawn counter=0, LFSR=10'h001, state=IDLE.
- FrameTick sampled at edge N -> updated PipeX/PipeY/PipeValid/Score visible after edge N, i.e. 1-cycle latency.
- ScorePulse is high for exactly the cycle following the tick edge.
- State change (Start/Collide/Restart) takes effect at the sampling edge. A FrameTick on the same edge as Start is not processed.
- Reset_n assertion mid-frame clears everything immediately (asynchronous). Deassertion is synchronized externally.

## Configuration
- PIPE_SPEEDUP_EN defined:
  - SPEED_cur = min(SPEED + Score[7:3], 4).
  - SPEED_cur is recomputed from the registered Score, so a new speed applies on the tick after the crossing.
- PIPE_SPEEDUP_EN undefined:
  - SPEED_cur = SPEED constant.
  - No speed-up logic synthesized.

## Test plan
- Reset, Start, one FrameTick -> slot 0 valid, PipeX=550, PipeY=80+lfsr[6:0] at that edge; slots 1,2 invalid; Running=1.
- Continuous ticks, SPEED=1 -> slot 0 X decrements by 1 per tick. Slot 1 spawns at X=550 on tick 121.
  - First ScorePulse occurs on the tick where X goes 200->199; Score=1.
- Slot X=1 on a tick -> PipeValid clears, X stays 1. A spawn due on that same tick takes the next free slot, not the retiring one.
- NUM_PIPES=1, SPAWN_FRAMES=2 -> spawns dropped while slot live; counter keeps wrapping; no X glitch.
- Collide and FrameTick same cycle -> DEAD, PipeX unchanged, no ScorePulse. Restart -> IDLE, all PipeValid=0, Score=0.
- PIPE_SPEEDUP_EN, force Score to 8 -> next ticks move by 2. At Score>=24 the step stays 4. Assert Reset_n mid-RUN -> all outputs zero immediately.
